// File: rtl/spi_wb_target.sv
// SPI mode-0 target that turns SPI frames into single-word 32-bit Wishbone master cycles.
// Optional macro SPI_WB_TIMEOUT_EN adds a Wishbone ack timeout of TIMEOUT_CYCLES clk.
module spi_wb_target #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  CMD_WRITE      = 8'h02,
  parameter logic [7:0]  CMD_READ       = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_sclk,
  input  logic        i_ss_n,
  input  logic        i_mosi,
  output logic        o_miso,
  output logic        o_miso_oe,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_SKIP
  } state_t;

  typedef enum logic {WB_IDLE, WB_REQ} wb_state_t;

  // [0],[1] synchronizer; [2] delay flop for edge detection
  logic [2:0]  r_sclk_sync;
  logic [2:0]  r_ss_sync;
  logic [1:0]  r_mosi_sync;

  state_t      r_state;
  state_t      w_state_nxt;
  wb_state_t   r_wb_state;
  wb_state_t   w_wb_nxt;

  logic [6:0]  r_bit_cnt;
  logic [31:0] r_rx;
  logic [31:0] r_addr;
  logic        r_is_rd;
  logic [31:0] r_tx;
  logic        r_err;
  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic        r_wb_we;
  logic        r_rd_pend;
  logic        r_rd_vld;
  logic [31:0] r_rdata;

  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_mosi;
  logic [31:0] w_rx_nxt;
  logic        w_shifting;
  logic        w_launch;
  logic        w_launch_we;
  logic        w_cmd_done;
  logic        w_addr_done;
  logic        w_bad_cmd;
  logic        w_load_tx;
  logic        w_wb_start;
  logic        w_wb_done;
  logic        w_launch_drop;
  logic        w_to_hit;
  logic        w_err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= 3'b000;
      r_ss_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], i_sclk};
      r_ss_sync   <= {r_ss_sync[1:0], i_ss_n};
      r_mosi_sync <= {r_mosi_sync[0], i_mosi};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_mosi      = r_mosi_sync[1];
  assign w_rx_nxt    = {r_rx[30:0], w_mosi};
  assign w_shifting  = (r_state inside {S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA});

  // Bit counter runs across the whole frame: cmd 0-7, addr 8-39, wdata 40-71 / dummy 40-47, rdata 48-79
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_launch_we = 1'b0;
    w_cmd_done  = 1'b0;
    w_addr_done = 1'b0;
    w_bad_cmd   = 1'b0;
    w_load_tx   = 1'b0;
    if (w_ss_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_ss_fall) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_sclk_rise && r_bit_cnt == 7'd7) begin
            w_cmd_done = 1'b1;
            if (w_rx_nxt[7:0] == CMD_WRITE || w_rx_nxt[7:0] == CMD_READ) begin
              w_state_nxt = S_ADDR;
            end else begin
              w_state_nxt = S_SKIP;
              w_bad_cmd   = 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_sclk_rise && r_bit_cnt == 7'd39) begin
            w_addr_done = 1'b1;
            if (r_is_rd) begin
              w_state_nxt = S_DUMMY;
              w_launch    = 1'b1;
            end else begin
              w_state_nxt = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (w_sclk_rise && r_bit_cnt == 7'd71) begin
            w_state_nxt = S_SKIP;
            w_launch    = 1'b1;
            w_launch_we = 1'b1;
          end
        end
        S_DUMMY: begin
          if (w_sclk_fall && r_bit_cnt == 7'd48) begin
            w_state_nxt = S_RDATA;
            w_load_tx   = 1'b1;
          end
        end
        S_RDATA: if (w_sclk_rise && r_bit_cnt == 7'd79) w_state_nxt = S_SKIP;
        S_SKIP:  w_state_nxt = S_SKIP;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wb_nxt      = r_wb_state;
    w_wb_start    = 1'b0;
    w_wb_done     = 1'b0;
    w_launch_drop = 1'b0;
    case (r_wb_state)
      WB_IDLE: begin
        if (w_launch) begin
          w_wb_nxt   = WB_REQ;
          w_wb_start = 1'b1;
        end
      end
      WB_REQ: begin
        w_launch_drop = w_launch;
        if (i_wb_ack) begin
          w_wb_nxt  = WB_IDLE;
          w_wb_done = 1'b1;
        end else if (w_to_hit) begin
          w_wb_nxt = WB_IDLE;
        end
      end
      default: w_wb_nxt = WB_IDLE;
    endcase
  end

`ifdef SPI_WB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_to_cnt <= '0;
    else if (r_wb_state != WB_REQ) r_to_cnt <= '0;
    else                           r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_to_hit = (r_wb_state == WB_REQ) && !i_wb_ack &&
                    (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  assign w_err_set = w_bad_cmd | w_launch_drop | (w_load_tx & ~r_rd_vld) | w_to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_addr    <= '0;
      r_is_rd   <= 1'b0;
      r_tx      <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ss_fall) begin
        r_bit_cnt <= '0;
      end else if (w_sclk_rise && w_shifting) begin
        r_bit_cnt <= r_bit_cnt + 7'd1;
        r_rx      <= w_rx_nxt;
      end
      if (w_cmd_done)  r_is_rd <= (w_rx_nxt[7:0] == CMD_READ);
      if (w_addr_done) r_addr  <= w_rx_nxt;
      if (w_load_tx)
        r_tx <= r_rd_vld ? r_rdata : 32'h0;
      else if (w_sclk_fall && r_state == S_RDATA)
        r_tx <= {r_tx[30:0], 1'b0};
      if (w_err_set)      r_err <= 1'b1;
      else if (w_ss_fall) r_err <= 1'b0;
    end
  end

  // A read result is kept only if the frame that asked for it is still open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_state <= WB_IDLE;
      r_wb_adr   <= '0;
      r_wb_dat   <= '0;
      r_wb_we    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_wb_state <= w_wb_nxt;
      if (w_wb_start) begin
        r_wb_adr <= w_launch_we ? r_addr : w_rx_nxt;
        r_wb_we  <= w_launch_we;
        if (w_launch_we) r_wb_dat <= w_rx_nxt;
      end
      if (w_ss_rise)                   r_rd_pend <= 1'b0;
      else if (w_wb_start)             r_rd_pend <= ~w_launch_we;
      else if (w_wb_done || w_to_hit)  r_rd_pend <= 1'b0;
      if (w_ss_fall || (w_wb_start && !w_launch_we)) begin
        r_rd_vld <= 1'b0;
      end else if (w_wb_done && r_rd_pend && !w_ss_rise) begin
        r_rd_vld <= 1'b1;
        r_rdata  <= i_wb_rdt;
      end else if (w_to_hit && r_rd_pend) begin
        r_rdata <= 32'h0;
      end
    end
  end

  assign o_miso    = (r_state == S_RDATA) & r_tx[31];
  assign o_miso_oe = ~r_ss_sync[1];
  assign o_busy    = (r_wb_state == WB_REQ);
  assign o_wb_cyc  = o_busy;
  assign o_wb_stb  = o_busy;
  assign o_wb_sel  = o_busy ? 4'hf : 4'h0;
  assign o_wb_adr  = r_wb_adr;
  assign o_wb_dat  = r_wb_dat;
  assign o_wb_we   = r_wb_we;
  assign o_err     = r_err;

endmodule
